// File: rtl/seq_reader_if.sv
// Signal bundle between the sequence reader and its host (memory, buttons, LEDs).
// Carries no timing or flow-control logic of its own.
interface seq_reader_if;
    logic       start_show;
    logic [4:0] seq_len;
    logic [3:0] mem_addr;
    logic [1:0] mem_data;
    logic [3:0] btn;
    logic [3:0] led;
    logic       input_ready;
    logic       cmp_result;
    logic       busy;

    modport master (
        output start_show, seq_len, mem_data, btn,
        input  mem_addr, led, input_ready, cmp_result, busy
    );

    modport slave (
        input  start_show, seq_len, mem_data, btn,
        output mem_addr, led, input_ready, cmp_result, busy
    );
endinterface

// File: rtl/seq_reader.sv
// Plays a colour sequence on one-hot LEDs, then checks the player's presses against it.
// Verdict one cycle after the deciding press edge; start_show is ignored while busy.
module seq_reader #(
    parameter int ON_CYC  = 4,
    parameter int OFF_CYC = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    seq_reader_if.slave bus
);

    localparam int MAXC = (ON_CYC > OFF_CYC) ? ((ON_CYC > TIMEOUT) ? ON_CYC : TIMEOUT)
                                             : ((OFF_CYC > TIMEOUT) ? OFF_CYC : TIMEOUT);
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, SHOW_ON, SHOW_OFF, WAIT_BTN, WAIT_REL} state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [4:0]      len_q, len_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      btn_prev_q, btn_prev_d;
    logic [3:0]      led_q, led_d;
    logic            input_ready_q, input_ready_d;
    logic            cmp_result_q, cmp_result_d;

    logic [3:0]      want;
    logic [4:0]      eff_len;
    logic            press;
    logic            last_step;

    always_comb begin
        want          = 4'b0001 << bus.mem_data;
        eff_len       = (bus.seq_len > 5'd16) ? 5'd16 : bus.seq_len;
        press         = (bus.btn != 4'b0) && (btn_prev_q == 4'b0);
        last_step     = ({1'b0, idx_q} == (len_q - 5'd1));

        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        btn_prev_d    = bus.btn;
        led_d         = 4'b0;
        input_ready_d = 1'b0;
        cmp_result_d  = cmp_result_q;

        case (state_q)
            IDLE: begin
                if (bus.start_show) begin
                    btn_prev_d = 4'b0;
                    len_d      = eff_len;
                    idx_d      = 4'd0;
                    cnt_d      = '0;
                    if (eff_len == 5'd0) begin
                        input_ready_d = 1'b1;
                        cmp_result_d  = 1'b0;
                    end else begin
                        state_d = SHOW_ON;
                    end
                end
            end
            SHOW_ON: begin
                // The display register trails the state by one cycle, so the
                // lit and dark windows keep their exact lengths.
                led_d = want;
                if (cnt_q == CW'(ON_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = SHOW_OFF;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHOW_OFF: begin
                if (cnt_q == CW'(OFF_CYC - 1)) begin
                    cnt_d = '0;
                    if (last_step) begin
                        idx_d   = 4'd0;
                        state_d = WAIT_BTN;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = SHOW_ON;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_BTN: begin
                if (press) begin
                    cnt_d = '0;
                    if (bus.btn == want && last_step) begin
                        input_ready_d = 1'b1;
                        cmp_result_d  = 1'b1;
                        state_d       = IDLE;
                    end else if (bus.btn == want) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = WAIT_REL;
                    end else begin
                        input_ready_d = 1'b1;
                        cmp_result_d  = 1'b0;
                        state_d       = IDLE;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d         = '0;
                    input_ready_d = 1'b1;
                    cmp_result_d  = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_REL: begin
                // The timeout keeps running while the player holds a button.
                if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d         = '0;
                    input_ready_d = 1'b1;
                    cmp_result_d  = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (bus.btn == 4'b0) begin
                        state_d = WAIT_BTN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= 4'd0;
            len_q         <= 5'd0;
            cnt_q         <= '0;
            btn_prev_q    <= 4'b0;
            led_q         <= 4'b0;
            input_ready_q <= 1'b0;
            cmp_result_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            btn_prev_q    <= btn_prev_d;
            led_q         <= led_d;
            input_ready_q <= input_ready_d;
            cmp_result_q  <= cmp_result_d;
        end
    end

    assign bus.mem_addr    = idx_q;
    assign bus.led         = led_q;
    assign bus.input_ready = input_ready_q;
    assign bus.cmp_result  = cmp_result_q;
    assign bus.busy        = (state_q != IDLE);

endmodule
